// File: rtl/cmd_seq.sv
// ---------------------------------------------------------------------------
// cmd_seq : command queue and sequencer for a UART-attached command channel.
//
// Commands are pushed into a circular FIFO. A start pulse drains the queue
// one command at a time: each command is issued with a one-cycle send_cmd
// strobe, then the sequencer waits for the transmitter (cmd_sent) and for the
// response byte (resp_rdy/resp). An ACK moves on to the next command. A NAK,
// an abort or (optionally) a timeout ends the sequence with a sticky error.
//
// Optional feature: define CMD_SEQ_TIMEOUT_EN to build a per-command timer
// that fails a command TIMEOUT cycles after issue if it is still waiting.
// Without the macro no timer exists and the wait states wait indefinitely.
//
// Parameters
//   DEPTH    queue entries (power of 2, 2..64)
//   TIMEOUT  cycles allowed per command from issue to response
//   ACK      positive response code
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   wr_en, wr_cmd       enqueue a 16-bit command word
//   start, abort        begin draining / stop and flush (one-cycle pulses)
//   cmd, send_cmd       command under issue (held) and its one-cycle strobe
//   cmd_sent            transmitter finished sending cmd
//   resp_rdy, resp      response byte and its valid
//   full, empty, count  queue status
//   busy, done          sequence active / completed (sticky until next start)
//   err, err_code       sticky error; 0 none, 1 timeout, 2 NAK, 3 aborted
//   issued              commands issued since start (wraps at 255)
// ---------------------------------------------------------------------------
module cmd_seq #(
    parameter int         DEPTH   = 8,
    parameter int         TIMEOUT = 1000000,
    parameter logic [7:0] ACK     = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [15:0]                wr_cmd,
    input  logic                       start,
    input  logic                       abort,
    output logic [15:0]                cmd,
    output logic                       send_cmd,
    input  logic                       cmd_sent,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [7:0]                 issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_TX   = 3'd2;
    localparam logic [2:0] S_WAIT_RESP = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    localparam logic [1:0] E_NONE    = 2'd0;
    localparam logic [1:0] E_TIMEOUT = 2'd1;
    localparam logic [1:0] E_NAK     = 2'd2;
    localparam logic [1:0] E_ABORT   = 2'd3;

    // Reject configurations the pointer arithmetic and timer cannot handle.
    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("cmd_seq: DEPTH must be a power of 2 in 2..64");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("cmd_seq: TIMEOUT must be at least 2");
    end

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          send_cmd_q, send_cmd_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    issued_q, issued_d;
    logic          push, pop, flush;

`ifdef CMD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] timer_q, timer_d;
    logic          timer_expired;

    // The timer saturates at TIMEOUT-1 so a late cmd_sent cannot wrap it.
    assign timer_expired = (timer_q == TW'(TIMEOUT - 1));
`endif

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT_TX) ||
                      (state_q == S_WAIT_RESP);
    assign cmd      = cmd_q;
    assign send_cmd = send_cmd_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign issued   = issued_q;

    // Sequencer: decides the next state, the issued command and the sticky
    // status flags. Abort is applied last so it overrides any response or
    // timeout seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        send_cmd_d = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        issued_d   = issued_q;
        pop        = 1'b0;
        flush      = 1'b0;
`ifdef CMD_SEQ_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!empty) begin
                        state_d    = S_ISSUE;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        err_code_d = E_NONE;
                        issued_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                pop        = 1'b1;
                cmd_d      = mem_q[rd_ptr_q];
                send_cmd_d = 1'b1;
                issued_d   = issued_q + 8'd1;
                state_d    = S_WAIT_TX;
`ifdef CMD_SEQ_TIMEOUT_EN
                timer_d    = '0;
`endif
            end
            S_WAIT_TX: begin
`ifdef CMD_SEQ_TIMEOUT_EN
                if (!timer_expired) timer_d = timer_q + TW'(1);
`endif
                if (cmd_sent) begin
                    state_d = S_WAIT_RESP;
                end
`ifdef CMD_SEQ_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = E_TIMEOUT;
                end
`endif
            end
            S_WAIT_RESP: begin
`ifdef CMD_SEQ_TIMEOUT_EN
                if (!timer_expired) timer_d = timer_q + TW'(1);
`endif
                if (resp_rdy) begin
                    if (resp == ACK) begin
                        if (!empty) begin
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = E_NAK;
                    end
                end
`ifdef CMD_SEQ_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = E_TIMEOUT;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && busy) begin
            state_d    = S_IDLE;
            flush      = 1'b1;
            pop        = 1'b0;
            send_cmd_d = 1'b0;
            cmd_d      = cmd_q;
            issued_d   = issued_q;
            err_d      = 1'b1;
            err_code_d = E_ABORT;
        end
    end

    // Queue bookkeeping. A push is refused whenever the queue is full at the
    // start of the cycle, even if the sequencer pops in that same cycle.
    always_comb begin
        push     = wr_en && !full && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Queue storage has no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_cmd;
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_q      <= 16'h0000;
            send_cmd_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
            issued_q   <= '0;
`ifdef CMD_SEQ_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cmd_q      <= cmd_d;
            send_cmd_q <= send_cmd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            issued_q   <= issued_d;
`ifdef CMD_SEQ_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

endmodule

// File: doc/cmd_seq.md
CMD_SEQ -- requirements
Module: cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8 (power of 2, 2..64): command queue entries.
REQ-002 SHALL have parameter TIMEOUT, default 1000000: cycles allowed per command from issue to response.
REQ-003 SHALL have parameter ACK, default 8'hA5: positive response code.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_en  input  1  enqueue wr_cmd this cycle.
REQ-007 wr_cmd  input  16  command word (for example 16'h2000 calibrate, {8'h40,hdg,1'b0,sq} move, {8'h60,x,y} tour).
REQ-008 start  input  1  one-cycle pulse that begins draining the queue.
REQ-009 abort  input  1  one-cycle pulse that stops the sequence and flushes the queue.
REQ-010 cmd  output  16  command being sent; held stable from issue until response.
REQ-011 send_cmd  output  1  one-cycle strobe to the UART command transmitter.
REQ-012 cmd_sent  input  1  transmitter finished sending cmd.
REQ-013 resp_rdy  input  1  response byte valid this cycle.
REQ-014 resp  input  8  response byte.
REQ-015 full, empty  output  1 each  queue status.
REQ-016 count  output  $clog2(DEPTH+1)  entries queued.
REQ-017 busy, done  output  1 each  sequence active; sequence completed (sticky until next start).
REQ-018 err  output  1  sticky error flag.
REQ-019 err_code  output  2  0 none, 1 timeout, 2 NAK, 3 aborted.
REQ-020 issued  output  8  commands issued since start; wraps at 255 to 0.

Function
REQ-021 Queue SHALL be a circular FIFO; wr_en when full SHALL be ignored, including when a pop occurs in the same cycle; push and pop in the same cycle when not full SHALL leave count unchanged.
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT_TX, WAIT_RESP, DONE, ERR.
REQ-023 IDLE: start with a non-empty queue goes to ISSUE and clears done, err, err_code and issued; start with an empty queue sets done and stays in IDLE.
REQ-024 ISSUE (one cycle): pop the head into cmd, pulse send_cmd and increment issued, then go to WAIT_TX.
REQ-025 WAIT_TX: cmd_sent goes to WAIT_RESP.
REQ-026 WAIT_RESP: resp_rdy with resp==ACK goes to ISSUE if the queue is non-empty, else to DONE.
REQ-027 WAIT_RESP: resp_rdy with resp!=ACK goes to ERR with err_code 2.
REQ-028 resp_rdy in a state other than WAIT_RESP SHALL be ignored.
REQ-029 DONE sets done, then returns to IDLE on the next cycle; ERR sets err, then returns to IDLE on the next cycle; entries still queued are retained.
REQ-030 busy SHALL be 1 in ISSUE, WAIT_TX and WAIT_RESP.
REQ-031 abort in any busy state SHALL go to IDLE, flush the queue, and set err with err_code 3; abort overrides a response or timeout in the same cycle.
REQ-032 start while busy SHALL be ignored.
REQ-033 Latency: start to send_cmd is 2 cycles; ACK to the next send_cmd is 2 cycles.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, an empty queue, count=0, cmd=16'h0000, send_cmd=0, busy=0, done=0, err=0, err_code=0, issued=0 and the timer to 0, including in the middle of a sequence.

Configuration
REQ-035 With CMD_SEQ_TIMEOUT_EN defined, a timer SHALL clear on ISSUE and count each cycle in WAIT_TX and WAIT_RESP; reaching TIMEOUT-1 without an exit goes to ERR with err_code 1; a response arriving on that same cycle takes priority over the timeout.
REQ-036 With CMD_SEQ_TIMEOUT_EN undefined, no timer SHALL be built, WAIT states SHALL wait indefinitely, and err_code 1 SHALL never occur.

Verification
REQ-037 Push 16'h2000 and 16'h6023, then start, ACK each response -> send_cmd pulses twice with cmd 2000 then 6023; done=1, issued=2, count=0.
REQ-038 Push 9 entries with DEPTH=8 -> full=1, count=8, 9th entry dropped; the drained sequence issues exactly 8.
REQ-039 Push 16'h4002, return resp=8'h5A -> err=1, err_code=2, done=0, the remaining queue entries retained.
REQ-040 CMD_SEQ_TIMEOUT_EN defined with TIMEOUT=100 and no cmd_sent -> err_code=1 exactly 100 cycles after send_cmd; macro undefined -> still busy after 1000 cycles.
REQ-041 abort during WAIT_RESP with 3 entries queued -> IDLE, count=0, err_code=3; rst_n low mid-sequence -> all outputs at reset values asynchronously.
